mips32_host_loader: RTL
=======================

MIPS32_HOST_LOADER -- requirements
Module: mips32_host_loader

Interface
REQ-001 Parameter ADDR_W, default 10: memory word-address width.
REQ-002 Parameter DATA_W, default 32: data word width.
REQ-003 Parameter TIMEOUT, default 4096: maximum run cycles before abort.
REQ-004 clk1  in  1  sole clock; the block SHALL use one clock, rising edge.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 cmd_valid / cmd_ready  in / out  1 / 1  host command handshake.
REQ-007 cmd_op  in  2  command: 00 WR_IMEM, 01 WR_DMEM, 10 RUN, 11 RD_DMEM.
REQ-008 cmd_addr / cmd_wdata  in  ADDR_W / DATA_W  command word address and write data.
REQ-009 rsp_valid / rsp_ready  out / in  1 / 1  response handshake; rsp_data out DATA_W; rsp_err out 1.
REQ-010 imem_we, imem_addr, imem_wdata  out  1, ADDR_W, DATA_W  instruction-memory write port.
REQ-011 dmem_we, dmem_re, dmem_addr, dmem_wdata  out  1, 1, ADDR_W, DATA_W  data-memory port; dmem_rdata in DATA_W.
REQ-012 core_hold  out  1  holds the core idle; core_start  out  1  one-cycle pulse clearing core PC, HALTED and TAKEN_BRANCH.
REQ-013 core_halted  in  1  core HLT status.

Function
REQ-014 FSM states: IDLE, WRITE, START, RUN, RD_REQ, RD_WAIT, RESP.
REQ-015 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid & cmd_ready.
REQ-016 WR_IMEM/WR_DMEM: IDLE->WRITE; imem_we or dmem_we high for exactly one cycle with registered addr/data; WRITE->RESP with rsp_data=0, rsp_err=0.
REQ-017 RUN: IDLE->START; core_start high one cycle, core_hold drops to 0 in the same cycle; START->RUN; 32-bit cycle counter cleared in START and incremented each RUN cycle.
REQ-018 In RUN, core_halted=1 SHALL move to RESP with rsp_data=cycle count, rsp_err=0; core_hold returns to 1.
REQ-019 In RUN, counter reaching TIMEOUT without halt SHALL move to RESP with rsp_data=all ones, rsp_err=1, core_hold=1; if halt and timeout coincide, halt wins.
REQ-020 RD_DMEM: IDLE->RD_REQ (dmem_re=1 one cycle) ->RD_WAIT (dmem_rdata valid, one-cycle memory latency) ->RESP with rsp_data=dmem_rdata captured.
REQ-021 RESP: rsp_valid=1, rsp_data/rsp_err stable until rsp_ready; on rsp_valid & rsp_ready -> IDLE; rsp_valid & cmd_ready never both 1.
REQ-022 At most one command in flight; write enables and dmem_re SHALL never be asserted outside their single designated cycle.
REQ-023 core_hold=1 in every state except START and RUN.
REQ-024 Addresses beyond 2^ADDR_W are not representable; cmd_addr used unmodified, no wrap logic.

Reset
REQ-025 rst_n=0 at a clk1 edge SHALL force IDLE, cmd_ready=0 during reset then 1 on the first cycle after release, rsp_valid=0, rsp_data=0, rsp_err=0, all memory strobes 0, core_start=0, core_hold=1, counter=0.
REQ-026 Reset during RUN or RESP SHALL abandon the command without a response; the core remains held.

Structure
REQ-027 Shared package mips32_pkg SHALL hold the cmd_op encodings, FSM state type and the all-ones timeout code.
REQ-028 One sub-module, mips32_run_timer (clear, enable, count, expired), is natural; everything else stays flat.

Verification
REQ-029 WR_IMEM addr 3 data 32'h21430000 -> single imem_we pulse with addr 3 and that data, response rsp_data=0, rsp_err=0.
REQ-030 WR_DMEM addr 200 data 7, then RD_DMEM addr 200 -> rsp_data=7 one cycle after RD_WAIT.
REQ-031 Load 11-word factorial program (HLT at word 10), dmem[200]=7, RUN, then RD_DMEM 198 -> RUN response rsp_err=0 with non-zero count, read returns 5040.
REQ-032 RUN with core_halted tied 0, TIMEOUT=16 -> response after 16 RUN cycles, rsp_data=32'hFFFFFFFF, rsp_err=1, core_hold=1.
REQ-033 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, cmd_ready=0 throughout.
REQ-034 Assert rst_n=0 mid-RUN -> next cycle IDLE state, core_hold=1, no rsp_valid pulse.

Source files
------------

// File: rtl/mips32_pkg.sv
// mips32_pkg: definitions shared by the host loader and its run timer.
//   cmd_op_e          host command encodings carried on cmd_op
//   loader_state_e    loader FSM states
//   RUN_TIMEOUT_CODE  response data returned when a run is aborted
package mips32_pkg;

  typedef enum logic [1:0] {
    OP_WR_IMEM = 2'b00,
    OP_WR_DMEM = 2'b01,
    OP_RUN     = 2'b10,
    OP_RD_DMEM = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_START,
    ST_RUN,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RESP
  } loader_state_e;

  localparam logic [31:0] RUN_TIMEOUT_CODE = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips32_run_timer.sv
// mips32_run_timer: 32-bit run-cycle counter with abort detection.
//   clk1, rst_n  clock and synchronous active-low reset
//   clear        zero the counter (wins over enable)
//   enable       count one cycle
//   count        cycles counted since the last clear
//   expired      high in the TIMEOUT-th enabled cycle after a clear
module mips32_run_timer #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  output logic [31:0] count,
  output logic        expired
);

  logic [31:0] r_count;

  always_ff @(posedge clk1) begin
    if (!rst_n || clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 32'd1;
    end
  end

  // r_count holds completed cycles, so the current cycle is r_count+1.
  assign expired = enable && (r_count >= 32'(TIMEOUT - 1));
  assign count   = r_count;

endmodule

// File: rtl/mips32_host_loader.sv
// mips32_host_loader: host command front-end for a MIPS32 core.
// Loads instruction/data memory, starts the core and waits for HLT or
// a timeout, and reads data memory back; one command in flight at a time.
//   clk1, rst_n                      clock, synchronous active-low reset
//   cmd_valid/ready/op/addr/wdata    host command channel
//   rsp_valid/ready/data/err         host response channel
//   imem_we/addr/wdata               instruction memory write port
//   dmem_we/re/addr/wdata, dmem_rdata data memory port (1-cycle read)
//   core_hold, core_start            core control; core_halted status
module mips32_host_loader
  import mips32_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              dmem_we,
  output logic              dmem_re,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              core_hold,
  output logic              core_start,
  input  logic              core_halted
);

  loader_state_e     r_state;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [DATA_W-1:0] r_imem_wdata;
  logic              r_dmem_we;
  logic              r_dmem_re;
  logic [ADDR_W-1:0] r_dmem_addr;
  logic [DATA_W-1:0] r_dmem_wdata;
  logic              r_core_hold;
  logic              r_core_start;

  logic [31:0]       w_count;
  logic              w_expired;

  mips32_run_timer #(.TIMEOUT(TIMEOUT)) u_run_timer (
    .clk1    (clk1),
    .rst_n   (rst_n),
    .clear   (r_state == ST_START),
    .enable  (r_state == ST_RUN),
    .count   (w_count),
    .expired (w_expired)
  );

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cmd_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_dmem_we    <= 1'b0;
      r_dmem_re    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_core_hold  <= 1'b1;
      r_core_start <= 1'b0;
    end else begin
      // Strobes are single-cycle: cleared here unless the case below re-arms them.
      r_imem_we    <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_re    <= 1'b0;
      r_core_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // cmd_ready is registered, so it rises one cycle after reset release.
          r_cmd_ready <= 1'b1;
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            case (cmd_op_e'(cmd_op))
              OP_WR_IMEM: begin
                r_imem_we    <= 1'b1;
                r_imem_addr  <= cmd_addr;
                r_imem_wdata <= cmd_wdata;
                r_state      <= ST_WRITE;
              end
              OP_WR_DMEM: begin
                r_dmem_we    <= 1'b1;
                r_dmem_addr  <= cmd_addr;
                r_dmem_wdata <= cmd_wdata;
                r_state      <= ST_WRITE;
              end
              OP_RUN: begin
                r_core_start <= 1'b1;
                r_core_hold  <= 1'b0;
                r_state      <= ST_START;
              end
              default: begin
                r_dmem_re   <= 1'b1;
                r_dmem_addr <= cmd_addr;
                r_state     <= ST_RD_REQ;
              end
            endcase
          end
        end
        ST_WRITE: begin
          r_rsp_data  <= '0;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_START: r_state <= ST_RUN;
        ST_RUN: begin
          // Halt is tested first so it wins when it coincides with expiry.
          if (core_halted) begin
            r_rsp_data  <= DATA_W'(w_count + 32'd1);
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_core_hold <= 1'b1;
            r_state     <= ST_RESP;
          end else if (w_expired) begin
            r_rsp_data  <= DATA_W'(RUN_TIMEOUT_CODE);
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_core_hold <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RD_REQ: r_state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          r_rsp_data  <= dmem_rdata;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_cmd_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_core_hold <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign dmem_we    = r_dmem_we;
  assign dmem_re    = r_dmem_re;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign core_hold  = r_core_hold;
  assign core_start = r_core_start;

endmodule
